// File: rtl/somador_pkg.sv
// Shared constants and width/bound helpers for the pipelined signed/unsigned adder.
package somador_pkg;

   localparam int CODIGO_A_SINAL = 0;
   localparam int CODIGO_B_SINAL = 1;
   localparam int LIM_W          = 64;

   function automatic int calc_we(input int w_a, input int w_s);
      return ((w_a > w_s) ? w_a : w_s) + 2;
   endfunction

   function automatic logic signed [LIM_W-1:0] limite_sup(input int w, input logic sinal);
      if (sinal) begin
         limite_sup = (64'sd1 <<< (w - 1)) - 64'sd1;
      end else begin
         limite_sup = (64'sd1 <<< w) - 64'sd1;
      end
   endfunction

   function automatic logic signed [LIM_W-1:0] limite_inf(input int w, input logic sinal);
      if (sinal) begin
         limite_inf = -(64'sd1 <<< (w - 1));
      end else begin
         limite_inf = 64'sd0;
      end
   endfunction

endpackage

// File: rtl/somador_sinal_pipeline_estende_operando.sv
// Sign- or zero-extends a W-bit operand to WE bits under a runtime signed flag.
module estende_operando #(
   parameter int W  = 8,
   parameter int WE = 10
) (
   input  logic [W-1:0]  valor_i,
   input  logic          sinal_i,
   output logic [WE-1:0] valor_o
);

   assign valor_o = sinal_i ? {{(WE-W){valor_i[W-1]}}, valor_i}
                            : {{(WE-W){1'b0}}, valor_i};

endmodule

// File: rtl/somador_sinal_pipeline.sv
// Two-stage valid/ready adder with per-transaction signedness, accumulation and overflow.
// Optional clamp on overflow when SOMADOR_SATURACAO_EN is defined (wrap otherwise).
module somador_sinal_pipeline
   import somador_pkg::*;
#(
   parameter int W_A = 8,
   parameter int W_B = 4,
   parameter int W_S = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W_A-1:0] op_a,
   input  logic [W_B-1:0] op_b,
   input  logic [1:0]     codigo,
   input  logic           acumular,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W_S-1:0] saida,
   output logic           overflow
);

   localparam int WE = calc_we(W_A, W_S);
   // One guard bit above WE so operand + operand + accumulator never wraps before the bound check.
   localparam int SW = WE + 1;

   localparam logic signed [LIM_W-1:0] SUP_S = limite_sup(W_S, 1'b1);
   localparam logic signed [LIM_W-1:0] SUP_U = limite_sup(W_S, 1'b0);
   localparam logic signed [LIM_W-1:0] INF_S = limite_inf(W_S, 1'b1);
   localparam logic signed [LIM_W-1:0] INF_U = limite_inf(W_S, 1'b0);

   logic [WE-1:0]            ext_a_s, ext_b_s;
   logic                     s1_valid_q, s1_sinal_q, s1_acum_q;
   logic [WE-1:0]            s1_a_q, s1_b_q;
   logic                     s2_valid_q, overflow_q;
   logic [W_S-1:0]           saida_q, acc_q;
   logic                     s2_pode_s, in_hs_s;
   logic [SW-1:0]            acc_ext_s;
   logic signed [SW-1:0]     soma_s;
   logic signed [LIM_W-1:0]  soma_ext_s, lim_sup_s, lim_inf_s;
   logic                     acima_s, abaixo_s, overflow_d;
   logic [W_S-1:0]           saida_d;

   estende_operando #(.W(W_A), .WE(WE)) u_ext_a (
      .valor_i (op_a),
      .sinal_i (codigo[CODIGO_A_SINAL]),
      .valor_o (ext_a_s)
   );

   estende_operando #(.W(W_B), .WE(WE)) u_ext_b (
      .valor_i (op_b),
      .sinal_i (codigo[CODIGO_B_SINAL]),
      .valor_o (ext_b_s)
   );

   assign s2_pode_s = !s2_valid_q || out_ready;
   assign in_ready  = !s1_valid_q || s2_pode_s;
   assign in_hs_s   = in_valid && in_ready;

   // Stage-2 sum, bound check and (optionally) clamping.
   always_comb begin
      acc_ext_s  = s1_sinal_q ? {{(SW-W_S){acc_q[W_S-1]}}, acc_q} : {{(SW-W_S){1'b0}}, acc_q};
      soma_s     = {s1_a_q[WE-1], s1_a_q} + {s1_b_q[WE-1], s1_b_q}
                 + (s1_acum_q ? acc_ext_s : {SW{1'b0}});
      soma_ext_s = {{(LIM_W-SW){soma_s[SW-1]}}, soma_s};
      lim_sup_s  = s1_sinal_q ? SUP_S : SUP_U;
      lim_inf_s  = s1_sinal_q ? INF_S : INF_U;
      acima_s    = soma_ext_s > lim_sup_s;
      abaixo_s   = soma_ext_s < lim_inf_s;
      overflow_d = acima_s || abaixo_s;
`ifdef SOMADOR_SATURACAO_EN
      if (acima_s) begin
         saida_d = lim_sup_s[W_S-1:0];
      end else if (abaixo_s) begin
         saida_d = lim_inf_s[W_S-1:0];
      end else begin
         saida_d = soma_s[W_S-1:0];
      end
`else
      saida_d = soma_s[W_S-1:0];
`endif
   end

   // Pipeline registers: S1 operand capture and S2 result/accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sinal_q <= 1'b0;
         s1_acum_q  <= 1'b0;
         s1_a_q     <= {WE{1'b0}};
         s1_b_q     <= {WE{1'b0}};
         s2_valid_q <= 1'b0;
         saida_q    <= {W_S{1'b0}};
         overflow_q <= 1'b0;
         acc_q      <= {W_S{1'b0}};
      end else begin
         if (in_ready) begin
            s1_valid_q <= in_valid;
         end
         if (in_hs_s) begin
            s1_a_q     <= ext_a_s;
            s1_b_q     <= ext_b_s;
            s1_sinal_q <= codigo[CODIGO_A_SINAL] | codigo[CODIGO_B_SINAL];
            s1_acum_q  <= acumular;
         end
         if (s2_pode_s) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               saida_q    <= saida_d;
               overflow_q <= overflow_d;
               acc_q      <= saida_d;
            end
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign saida     = saida_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_somador_sinal_pipeline.sv
// Directed self-checking bench for somador_sinal_pipeline (default 8/4/8 widths).
module tb_somador_sinal_pipeline;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready, acumular, overflow;
   logic [7:0] op_a, saida;
   logic [3:0] op_b;
   logic [1:0] codigo;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   somador_sinal_pipeline #(.W_A(8), .W_B(4), .W_S(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .codigo(codigo), .acumular(acumular),
      .out_valid(out_valid), .out_ready(out_ready), .saida(saida), .overflow(overflow)
   );

   // Drives one transaction from an idle pipeline with out_ready=1 and returns result and latency.
   task automatic run_txn(input logic [7:0] a, input logic [3:0] b, input logic [1:0] c,
                          input logic ac, output logic [7:0] s, output logic ov, output int lat);
      int w;
      op_a = a; op_b = b; codigo = c; acumular = ac; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      w = 0;
      while (!in_ready && w < 20) begin
         @(negedge clk); #1; w++;
      end
      @(negedge clk);
      in_valid = 1'b0; op_a = 8'h00; op_b = 4'h0; codigo = 2'd0; acumular = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk); lat++;
      end
      s = saida; ov = overflow;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op_a = 8'h00; op_b = 4'h0;
      codigo = 2'd0; acumular = 1'b0;
      #12;
      n_tests++;
      if (out_valid !== 1'b0 || saida !== 8'h00 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL reset_state: valid=%b saida=%h ovf=%b, required 0/00/0", out_valid, saida, overflow);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
   endtask

   task automatic test_signed_basic();
      logic [7:0] s; logic ov; int lat;
      run_txn(8'hF0, 4'h9, 2'd3, 1'b0, s, ov, lat);
      n_tests++;
      if (s !== 8'hE9 || ov !== 1'b0) begin
         n_fail++; $display("FAIL signed_basic: saida=%h ovf=%b, required e9/0", s, ov);
      end
      n_tests++;
      if (lat !== 2) begin
         n_fail++; $display("FAIL latency: got %0d cycles, required 2", lat);
      end
   endtask

   task automatic test_unsigned_overflow();
      logic [7:0] s; logic ov; int lat;
      logic [7:0] esperado;
`ifdef SOMADOR_SATURACAO_EN
      esperado = 8'hFF;
`else
      esperado = 8'h0E;
`endif
      run_txn(8'hFF, 4'hF, 2'd0, 1'b0, s, ov, lat);
      n_tests++;
      if (s !== esperado || ov !== 1'b1) begin
         n_fail++; $display("FAIL unsigned_overflow: saida=%h ovf=%b, required %h/1", s, ov, esperado);
      end
   endtask

   task automatic test_mixed_sign();
      logic [7:0] s; logic ov; int lat;
      run_txn(8'h80, 4'hF, 2'd1, 1'b0, s, ov, lat);
      n_tests++;
      if (s !== 8'h8F || ov !== 1'b0) begin
         n_fail++; $display("FAIL mixed_a_signed: saida=%h ovf=%b, required 8f/0", s, ov);
      end
      run_txn(8'h80, 4'h8, 2'd2, 1'b0, s, ov, lat);
      n_tests++;
      if (s !== 8'h78 || ov !== 1'b0) begin
         n_fail++; $display("FAIL mixed_b_signed: saida=%h ovf=%b, required 78/0", s, ov);
      end
   endtask

   task automatic test_accumulate();
      logic [7:0] s; logic ov; int lat;
      logic [7:0] esperado;
`ifdef SOMADOR_SATURACAO_EN
      esperado = 8'h7F;
`else
      esperado = 8'h96;
`endif
      run_txn(8'd100, 4'h0, 2'd3, 1'b0, s, ov, lat);
      n_tests++;
      if (s !== 8'h64 || ov !== 1'b0) begin
         n_fail++; $display("FAIL acc_first: saida=%h ovf=%b, required 64/0", s, ov);
      end
      run_txn(8'd50, 4'h0, 2'd3, 1'b1, s, ov, lat);
      n_tests++;
      if (s !== esperado || ov !== 1'b1) begin
         n_fail++; $display("FAIL acc_overflow: saida=%h ovf=%b, required %h/1", s, ov, esperado);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] esp [4] = '{8'd10, 8'd21, 8'd32, 8'd43};
      logic [7:0] cur;
      logic hs_in, hs_out;
      int sent, got, last;
      sent = 0; got = 0; last = -1; out_ready = 1'b0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         if (cyc == 6) out_ready = 1'b1;
         in_valid = (sent < 4);
         op_a = 8'((sent + 1) * 10); op_b = 4'(sent); codigo = 2'd0; acumular = 1'b0;
         #1;
         if (cyc == 5) begin
            n_tests++;
            if (in_ready !== 1'b0 || sent !== 2) begin
               n_fail++; $display("FAIL stall_accepts: in_ready=%b accepted=%0d, required 0/2", in_ready, sent);
            end
            n_tests++;
            if (out_valid !== 1'b1 || saida !== esp[0]) begin
               n_fail++; $display("FAIL stall_hold: valid=%b saida=%h, required 1/%h", out_valid, saida, esp[0]);
            end
         end
         hs_in = in_valid && in_ready;
         hs_out = out_valid && out_ready;
         cur = saida;
         @(negedge clk);
         if (hs_in) sent++;
         if (hs_out) begin
            n_tests++;
            if (cur !== esp[got] || (got > 0 && cyc !== last + 1)) begin
               n_fail++; $display("FAIL bp_order[%0d]: saida=%h at cycle %0d, required %h at cycle %0d", got, cur, cyc, esp[got], last + 1);
            end
            got++; last = cyc;
         end
      end
      in_valid = 1'b0;
      n_tests++;
      if (got !== 4) begin
         n_fail++; $display("FAIL bp_count: got %0d results, required 4", got);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] s; logic ov; int lat;
      out_ready = 1'b0; in_valid = 1'b1; op_a = 8'd7; op_b = 4'd1; codigo = 2'd3; acumular = 1'b0;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      #2;
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL mid_setup: valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || saida !== 8'h00 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset: valid=%b saida=%h ovf=%b, required 0/00/0", out_valid, saida, overflow);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      run_txn(8'd5, 4'h0, 2'd3, 1'b1, s, ov, lat);
      n_tests++;
      if (s !== 8'h05 || ov !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_acc: saida=%h ovf=%b, required 05/0", s, ov);
      end
   endtask

   initial begin
      test_reset();
      test_signed_basic();
      test_unsigned_overflow();
      test_mixed_sign();
      test_accumulate();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
